wb_interconnect: RTL

- Single-master, three-slave Wishbone (pipelined-style stb/stall/ack) bus controller between `cpu` and the SoC memories/peripherals.
- Decodes the master address, routes strobes to exactly one slave, and muxes that slave's data/ack back.
- Enforces one outstanding transaction at a time.
- Unmapped accesses and hung slaves get a bus error instead of deadlocking the core.

---
 rtl/soc_bus_pkg.sv | 27 ++
 rtl/wb_addr_decode.sv | 20 ++
 rtl/wb_interconnect.sv | 87 ++++++++
 3 files changed

// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: address map, slave indices and FSM encoding for the SoC Wishbone bus.
//   Contents: BOOTROM/RAM/IO base+mask pairs, S_* slave indices, ST_* state codes,
//   bit_at() helper selecting one bit of a per-slave vector by slave index.
package soc_bus_pkg;

    localparam logic [31:0] BOOTROM_BASE = 32'hb000_0000;
    localparam logic [31:0] BOOTROM_MASK = 32'hffff_8000;
    localparam logic [31:0] RAM_BASE     = 32'hb000_8000;
    localparam logic [31:0] RAM_MASK     = 32'hffff_8000;
    localparam logic [31:0] IO_BASE      = 32'hc000_0000;
    localparam logic [31:0] IO_MASK      = 32'hffff_0000;

    localparam logic [1:0] S_BOOTROM = 2'd0;
    localparam logic [1:0] S_RAM     = 2'd1;
    localparam logic [1:0] S_IO      = 2'd2;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_ERR  = 2'd2;

    // Index 3 never occurs; it falls back to the bootrom bit rather than reading out of range.
    function automatic logic bit_at(input logic [2:0] v, input logic [1:0] i);
        return i == S_IO ? v[2] : i == S_RAM ? v[1] : v[0];
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// wb_addr_decode: combinational master address -> slave index decoder.
//   addr   in  32  master byte address
//   mapped out 1   address hits bootrom, RAM or IO
//   dec    out 2   slave index (S_BOOTROM/S_RAM/S_IO), S_BOOTROM when unmapped
module wb_addr_decode
    import soc_bus_pkg::*;
(
    input  logic [31:0] addr,
    output logic        mapped,
    output logic [1:0]  dec
);
    logic rom, ram, io;
    always_comb begin
        rom    = (addr & BOOTROM_MASK) == BOOTROM_BASE;
        ram    = (addr & RAM_MASK) == RAM_BASE;
        io     = (addr & IO_MASK) == IO_BASE;
        mapped = rom | ram | io;
        dec    = io ? S_IO : ram ? S_RAM : S_BOOTROM;
    end
endmodule

// File: rtl/wb_interconnect.sv
// wb_interconnect: single-master, three-slave pipelined Wishbone controller with
// one outstanding transaction, bus error on unmapped access or slave timeout.
//   clk, reset          clock, async active-high reset
//   i_wb_*/i_we/i_addr/i_data   master request;  o_data/o_wb_stall/o_wb_ack/o_wb_err to master
//   o_s_addr/o_s_data/o_s_we    passthrough to all slaves;  o_s_stb one-hot slave strobe
//   i_s_stall/i_s_ack/i_s_data* per-slave responses;  o_err_count saturating error count
module wb_interconnect
    import soc_bus_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_we,
    input  logic [31:0]      i_addr,
    input  logic [31:0]      i_data,
    output logic [31:0]      o_data,
    output logic             o_wb_stall,
    output logic             o_wb_ack,
    output logic             o_wb_err,
    output logic [31:0]      o_s_addr,
    output logic [31:0]      o_s_data,
    output logic             o_s_we,
    output logic [2:0]       o_s_stb,
    input  logic [2:0]       i_s_stall,
    input  logic [2:0]       i_s_ack,
    input  logic [31:0]      i_s_data0,
    input  logic [31:0]      i_s_data1,
    input  logic [31:0]      i_s_data2,
    output logic [CNT_W-1:0] o_err_count
);
    logic       mapped;
    logic [1:0] dec;
    state_t     state;
    logic [1:0] sel;
    logic [7:0] tmo;
    logic       err_q;
    logic       idle, busy, req, timeout;

    wb_addr_decode u_dec (.addr(i_addr), .mapped(mapped), .dec(dec));

    always_comb begin
        idle       = state == ST_IDLE;
        busy       = state == ST_BUSY;
        req        = i_wb_cyc & i_wb_stb;
        o_s_addr   = i_addr;
        o_s_data   = i_data;
        o_s_we     = i_we;
        // Unmapped requests never stall, so they are accepted straight into ERR.
        o_wb_stall = idle ? i_wb_stb & mapped & bit_at(i_s_stall, dec) : 1'b1;
        o_s_stb    = (idle & req & mapped) ? 3'b001 << dec : 3'b000;
        // A dropped cyc suppresses the ack so an aborted cycle never completes.
        o_wb_ack   = busy & i_wb_cyc & bit_at(i_s_ack, sel);
        o_data     = !o_wb_ack ? 32'h0 : sel == S_IO ? i_s_data2 : sel == S_RAM ? i_s_data1 : i_s_data0;
        timeout    = busy & i_wb_cyc & !o_wb_ack & (tmo == 8'(TIMEOUT - 1));
        o_wb_err   = err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            sel         <= S_BOOTROM;
            tmo         <= 8'd0;
            err_q       <= 1'b0;
            o_err_count <= '0;
        end else begin
            err_q <= timeout | (idle & req & !mapped);
            if (err_q && o_err_count != '1)
                o_err_count <= o_err_count + CNT_W'(1);
            case (state)
                ST_IDLE: if (req && !o_wb_stall) begin
                    state <= mapped ? ST_BUSY : ST_ERR;
                    sel   <= mapped ? dec : sel;
                    tmo   <= 8'd0;
                end
                ST_BUSY: begin
                    tmo   <= tmo + 8'd1;
                    state <= (!i_wb_cyc || o_wb_ack || timeout) ? ST_IDLE : ST_BUSY;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
